br_predict_cmp: RTL and testbench

- Parametrised successor to the ID-stage branch comparator: resolves MIPS conditional branches at a configurable data width.
- Adds an optional registered resolve stage and a bimodal branch history table (BHT) of 2-bit saturating counters.
- The IF stage reads a taken prediction; the ID stage resolves the branch, flags a mispredict, and trains the BHT.
- Hit and mispredict statistics counters are included for the performance CSR.

---
 rtl/br_predict_cmp.sv | 148 ++++++++++++++
 tb/tb_br_predict_cmp.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/br_predict_cmp.sv
// MIPS conditional-branch resolver with an optional registered resolve stage,
// a bimodal 2-bit BHT for fetch-time prediction, and branch/mispredict statistics.
module br_predict_cmp #(
  parameter int DATA_W     = 32,
  parameter int BHT_DEPTH  = 64,
  parameter int CMP_STAGES = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       if_pc,
  output logic              if_pred_taken,
  input  logic              id_valid,
  input  logic              id_stall,
  input  logic [31:0]       id_instr,
  input  logic [31:0]       id_pc,
  input  logic              id_pred_taken,
  input  logic [DATA_W-1:0] RData1,
  input  logic [DATA_W-1:0] RData2,
  output logic              br_valid,
  output logic              br_taken,
  output logic              br_link,
  output logic              br_mispredict,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stat_branches,
  output logic [CNT_W-1:0]  stat_mispred
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic [5:0] opcode;
  logic [4:0] rt;
  logic       is_br, cond, link;
  logic       a_neg, a_zero;
  logic       fire, br_fire;
  logic       res_valid, res_taken, res_link, res_mis;

  assign opcode = id_instr[31:26];
  assign rt     = id_instr[20:16];
  assign a_neg  = RData1[DATA_W-1];
  assign a_zero = (RData1 == '0);

  always_comb begin
    is_br = 1'b0;
    cond  = 1'b0;
    link  = 1'b0;
    case (opcode)
      6'b000100: begin is_br = 1'b1; cond = (RData1 == RData2); end
      6'b000101: begin is_br = 1'b1; cond = (RData1 != RData2); end
      6'b000110: begin is_br = 1'b1; cond = a_neg | a_zero; end
      6'b000111: begin is_br = 1'b1; cond = ~a_neg & ~a_zero; end
      6'b000001: begin
        case (rt)
          5'b00000: begin is_br = 1'b1; cond = a_neg; end
          5'b00001: begin is_br = 1'b1; cond = ~a_neg; end
          5'b10000: begin is_br = 1'b1; cond = a_neg;  link = 1'b1; end
          5'b10001: begin is_br = 1'b1; cond = ~a_neg; link = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign fire      = id_valid & ~id_stall;
  assign br_fire   = fire & is_br;
  assign res_valid = br_fire;
  assign res_taken = br_fire & cond;
  assign res_link  = br_fire & link;
  assign res_mis   = br_fire & (cond != id_pred_taken);

  generate
    if (CMP_STAGES == 0) begin : g_comb
      assign br_valid      = res_valid;
      assign br_taken      = res_taken;
      assign br_link       = res_link;
      assign br_mispredict = res_mis;
    end else begin : g_reg
      logic valid_q, taken_q, link_q, mis_q;
      // A stall freezes the last resolve; any other non-fire cycle clears it.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          valid_q <= 1'b0;
          taken_q <= 1'b0;
          link_q  <= 1'b0;
          mis_q   <= 1'b0;
        end else if (!id_stall) begin
          valid_q <= res_valid;
          taken_q <= res_taken;
          link_q  <= res_link;
          mis_q   <= res_mis;
        end
      end
      assign br_valid      = valid_q;
      assign br_taken      = taken_q;
      assign br_link       = link_q;
      assign br_mispredict = mis_q;
    end
  endgenerate

  logic [1:0]       bht_q [BHT_DEPTH];
  logic [IDX_W-1:0] if_idx, upd_idx;
  logic [1:0]       ctr_cur, ctr_d;

  assign if_idx        = if_pc[IDX_W+1:2];
  assign upd_idx       = id_pc[IDX_W+1:2];
  assign if_pred_taken = bht_q[if_idx][1];
  assign ctr_cur       = bht_q[upd_idx];

  always_comb begin
    ctr_d = ctr_cur;
    if (cond && ctr_cur != 2'b11)
      ctr_d = ctr_cur + 2'b01;
    else if (!cond && ctr_cur != 2'b00)
      ctr_d = ctr_cur - 2'b01;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
    end else if (br_fire) begin
      bht_q[upd_idx] <= ctr_d;
    end
  end

  logic [CNT_W-1:0] stat_br_q, stat_mis_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else if (stat_clr) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else if (br_fire) begin
      stat_br_q <= stat_br_q + CNT_W'(1);
      if (res_mis) stat_mis_q <= stat_mis_q + CNT_W'(1);
    end
  end

  assign stat_branches = stat_br_q;
  assign stat_mispred  = stat_mis_q;

  logic unused_bits;
  assign unused_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0], id_pc[31:IDX_W+2], id_pc[1:0],
                         id_instr[25:21], id_instr[15:0]};

endmodule

// File: tb/tb_br_predict_cmp.sv
// Directed bench: a combinational-resolve instance and a registered-resolve
// instance share the same stimulus; expected values are hand-computed.
module tb_br_predict_cmp;

  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_BLEZ = 6'b000110,
                         OP_BGTZ = 6'b000111, OP_RIMM = 6'b000001, OP_J = 6'b000010;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] if_pc = '0;
  logic        id_valid = 1'b0, id_stall = 1'b0, id_pred_taken = 1'b0, stat_clr = 1'b0;
  logic [31:0] id_instr = '0, id_pc = '0, RData1 = '0, RData2 = '0;

  logic        p0, v0, t0, l0, m0;
  logic [15:0] sb0, sm0;
  logic        p1, v1, t1, l1, m1;
  logic [15:0] sb1, sm1;

  int total = 0;
  int bad = 0;

  br_predict_cmp #(.DATA_W(32), .BHT_DEPTH(64), .CMP_STAGES(0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_pred_taken(p0),
    .id_valid(id_valid), .id_stall(id_stall), .id_instr(id_instr), .id_pc(id_pc),
    .id_pred_taken(id_pred_taken), .RData1(RData1), .RData2(RData2),
    .br_valid(v0), .br_taken(t0), .br_link(l0), .br_mispredict(m0),
    .stat_clr(stat_clr), .stat_branches(sb0), .stat_mispred(sm0));

  br_predict_cmp #(.DATA_W(32), .BHT_DEPTH(64), .CMP_STAGES(1), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_pred_taken(p1),
    .id_valid(id_valid), .id_stall(id_stall), .id_instr(id_instr), .id_pc(id_pc),
    .id_pred_taken(id_pred_taken), .RData1(RData1), .RData2(RData2),
    .br_valid(v1), .br_taken(t1), .br_link(l1), .br_mispredict(m1),
    .stat_clr(stat_clr), .stat_branches(sb1), .stat_mispred(sm1));

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic        pred;
    logic        v, t, l, m;
  } vec_t;

  vec_t vecs[18];

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rtf);
    return {op, 5'd3, rtf, 16'h0010};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0;
    id_stall = 1'b0;
    stat_clr = 1'b0;
  endtask

  task automatic fire(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                      input logic pred, input logic [31:0] pc);
    id_valid = 1'b1;
    id_stall = 1'b0;
    id_instr = instr;
    RData1 = a;
    RData2 = b;
    id_pred_taken = pred;
    id_pc = pc;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    int exp_br, exp_mis, sweep_bad;

    vecs[0]  = '{mk(OP_BEQ, 5'd0),   32'd5,        32'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{mk(OP_BEQ, 5'd0),   32'd5,        32'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{mk(OP_BNE, 5'd0),   32'd1,        32'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{mk(OP_BNE, 5'd0),   32'd7,        32'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{mk(OP_BLEZ, 5'd0),  32'h80000000, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{mk(OP_BLEZ, 5'd0),  32'd0,        32'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{mk(OP_BLEZ, 5'd0),  32'd1,        32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{mk(OP_BGTZ, 5'd0),  32'd0,        32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{mk(OP_BGTZ, 5'd0),  32'h7FFFFFFF, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{mk(OP_RIMM, 5'd0),  32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{mk(OP_RIMM, 5'd0),  32'd0,        32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{mk(OP_RIMM, 5'd1),  32'd0,        32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{mk(OP_RIMM, 5'd1),  32'h80000000, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{mk(OP_RIMM, 5'd16), 32'hFFFFFFFF, 32'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{mk(OP_RIMM, 5'd17), 32'hFFFFFFFF, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[15] = '{mk(OP_J, 5'd0),     32'd4,        32'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{mk(OP_RIMM, 5'd2),  32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{mk(6'b000000, 5'd1), 32'd0,       32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset state and a full-index prediction sweep
    do_reset();
    sweep_bad = 0;
    for (int i = 0; i < 64; i++) begin
      if_pc = 32'(i * 4);
      #1;
      if (p0 !== 1'b0) sweep_bad++;
    end
    chk("reset_pred_sweep_errors", 32'(sweep_bad), 32'd0);
    chk("reset_stat_branches", 32'(sb0), 32'd0);
    chk("reset_stat_mispred", 32'(sm0), 32'd0);
    chk("reset_reg_valid", 32'(v1), 32'd0);

    // Same-cycle beq resolve and BHT training
    fire(mk(OP_BEQ, 5'd0), 32'h1234, 32'h1234, 1'b0, 32'h3000);
    #1;
    chk("beq_valid", 32'(v0), 32'd1);
    chk("beq_taken", 32'(t0), 32'd1);
    chk("beq_mispredict", 32'(m0), 32'd1);
    tick();
    idle();
    if_pc = 32'h3000;
    #1;
    chk("beq_pred_after", 32'(p0), 32'd1);
    chk("beq_stat_branches", 32'(sb0), 32'd1);
    chk("beq_stat_mispred", 32'(sm0), 32'd1);

    // Decode table on the combinational instance
    do_reset();
    exp_br = 0;
    exp_mis = 0;
    for (int i = 0; i < 18; i++) begin
      fire(vecs[i].instr, vecs[i].a, vecs[i].b, vecs[i].pred, 32'h1000 + 32'(i * 4));
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(v0), 32'(vecs[i].v));
      chk($sformatf("vec%0d_taken", i), 32'(t0), 32'(vecs[i].t));
      chk($sformatf("vec%0d_link", i), 32'(l0), 32'(vecs[i].l));
      chk($sformatf("vec%0d_mispred", i), 32'(m0), 32'(vecs[i].m));
      exp_br += int'(vecs[i].v);
      exp_mis += int'(vecs[i].m);
      tick();
    end
    idle();
    #1;
    chk("table_stat_branches", 32'(sb0), 32'(exp_br));
    chk("table_stat_mispred", 32'(sm0), 32'(exp_mis));
    if_pc = 32'h1000;
    #1;
    chk("table_pred_taken_idx0", 32'(p0), 32'd1);
    if_pc = 32'h1004;
    #1;
    chk("table_pred_nottaken_idx1", 32'(p0), 32'd0);

    // Saturation at pc 0x40
    do_reset();
    if_pc = 32'h40;
    for (int k = 1; k <= 5; k++) begin
      fire(mk(OP_BEQ, 5'd0), 32'd8, 32'd8, 1'b1, 32'h40);
      tick();
      idle();
      #1;
      chk($sformatf("sat_taken%0d_pred", k), 32'(p0), 32'd1);
    end
    fire(mk(OP_BEQ, 5'd0), 32'd8, 32'd9, 1'b1, 32'h40);
    tick();
    idle();
    #1;
    chk("sat_nt1_pred", 32'(p0), 32'd1);
    fire(mk(OP_BEQ, 5'd0), 32'd8, 32'd9, 1'b1, 32'h40);
    tick();
    idle();
    #1;
    chk("sat_nt2_pred", 32'(p0), 32'd0);

    // Aliasing, non-branches and stalled branches
    do_reset();
    fire(mk(OP_BEQ, 5'd0), 32'd1, 32'd1, 1'b0, 32'h40);
    tick();
    idle();
    if_pc = 32'h140;
    #1;
    chk("alias_pred_0x140", 32'(p0), 32'd1);
    fire(mk(OP_J, 5'd0), 32'd1, 32'd2, 1'b1, 32'h40);
    #1;
    chk("j_valid", 32'(v0), 32'd0);
    tick();
    fire(mk(OP_RIMM, 5'd2), 32'd1, 32'd2, 1'b1, 32'h40);
    #1;
    chk("regimm2_valid", 32'(v0), 32'd0);
    tick();
    fire(mk(OP_BEQ, 5'd0), 32'd1, 32'd2, 1'b1, 32'h40);
    id_stall = 1'b1;
    #1;
    chk("stalled_valid", 32'(v0), 32'd0);
    tick();
    idle();
    #1;
    chk("nonbr_pred_kept", 32'(p0), 32'd1);
    chk("nonbr_stat_branches", 32'(sb0), 32'd1);
    chk("nonbr_stat_mispred", 32'(sm0), 32'd1);

    // Registered resolve: one-cycle latency and hold through stall
    do_reset();
    fire(mk(OP_BNE, 5'd0), 32'd1, 32'd2, 1'b0, 32'h80);
    #1;
    chk("reg_valid_before", 32'(v1), 32'd0);
    tick();
    id_stall = 1'b1;
    #1;
    chk("reg_valid", 32'(v1), 32'd1);
    chk("reg_taken", 32'(t1), 32'd1);
    chk("reg_mispred", 32'(m1), 32'd1);
    chk("reg_link", 32'(l1), 32'd0);
    for (int s = 1; s <= 2; s++) begin
      tick();
      chk($sformatf("reg_hold%0d_valid", s), 32'(v1), 32'd1);
      chk($sformatf("reg_hold%0d_taken", s), 32'(t1), 32'd1);
    end
    chk("reg_stat_branches", 32'(sb1), 32'd1);
    fire(mk(OP_BNE, 5'd0), 32'd3, 32'd3, 1'b0, 32'h80);
    tick();
    idle();
    if_pc = 32'h80;
    #1;
    chk("reg_next_valid", 32'(v1), 32'd1);
    chk("reg_next_taken", 32'(t1), 32'd0);
    chk("reg_next_mispred", 32'(m1), 32'd0);
    chk("reg_bht_once_pred", 32'(p1), 32'd0);
    tick();
    chk("reg_idle_valid", 32'(v1), 32'd0);

    // Reset asserted while a registered resolve is held by a stall
    fire(mk(OP_BNE, 5'd0), 32'd1, 32'd2, 1'b0, 32'h80);
    tick();
    id_stall = 1'b1;
    #1;
    chk("rst_pre_valid", 32'(v1), 32'd1);
    reset = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(v1), 32'd0);
    chk("rst_mid_taken", 32'(t1), 32'd0);
    chk("rst_mid_pred", 32'(p1), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    idle();
    tick();
    chk("rst_after_valid", 32'(v1), 32'd0);
    chk("rst_after_stats", 32'(sb1), 32'd0);

    // stat_clr has priority over a same-cycle increment
    fire(mk(OP_BEQ, 5'd0), 32'd2, 32'd2, 1'b0, 32'h100);
    tick();
    #1;
    chk("clr_pre_branches", 32'(sb1), 32'd1);
    stat_clr = 1'b1;
    tick();
    idle();
    #1;
    chk("clr_branches", 32'(sb1), 32'd0);
    chk("clr_mispred", 32'(sm1), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
